// File: rtl/jtag_burst_dma.sv
// Burst DMA between the JTAG dual-port buffer and the system bus, 1..MAX_BURST words per transaction.
// Define JTAG_DMA_BURST_EN for multi-word bursts; otherwise every transfer is a single word.

// jtag_dma_fifo: show-ahead FIFO staging buffer words ahead of the bus.
// Latency: a pushed word is visible at the head on the following cycle.
// Backpressure: push ignored when full, pop ignored when empty; flush overrides both.
module jtag_dma_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_rdy,
   output logic [W-1:0] head_dat,
   output logic         head_vld
);
   generate
      if (DEPTH == 1) begin : g_reg
         logic [W-1:0] dat_q;
         logic         vld_q;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               dat_q <= '0;
               vld_q <= 1'b0;
            end else if (flush) begin
               vld_q <= 1'b0;
            end else if (push_vld && !vld_q) begin
               dat_q <= push_dat;
               vld_q <= 1'b1;
            end else if (pop_rdy && vld_q) begin
               vld_q <= 1'b0;
            end
         end

         assign head_dat = dat_q;
         assign head_vld = vld_q;
      end else begin : g_ram
         localparam int AW = $clog2(DEPTH);
         logic [W-1:0]  mem [DEPTH];
         logic [AW-1:0] wr_ptr, rd_ptr;
         logic [AW:0]   cnt;
         logic          do_push, do_pop;

         assign do_push = push_vld && (cnt != DEPTH[AW:0]) && !flush;
         assign do_pop  = pop_rdy && (cnt != '0) && !flush;

         always_ff @(posedge clock) begin
            if (do_push) mem[wr_ptr] <= push_dat;
         end

         // DEPTH is a power of two, so the pointers wrap naturally.
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               cnt    <= '0;
            end else if (flush) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               cnt    <= '0;
            end else begin
               if (do_push) wr_ptr <= wr_ptr + 1'b1;
               if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
               cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
            end
         end

         assign head_dat = mem[rd_ptr];
         assign head_vld = (cnt != '0);
      end
   endgenerate
endmodule

// jtag_burst_dma: buffer->bus write bursts (prefetched into a FIFO) and bus->buffer read bursts.
// Latency: write begins after N+1 fetch cycles plus arbitration; read words hit the buffer in their valid cycle.
// Backpressure: busyIN holds the FIFO head on the bus; the buffer is never touched while the bus stalls.
module jtag_burst_dma #(
   parameter int BUF_ADDR_W = 9,
   parameter int MAX_BURST  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ipcore_dataReady,
   input  logic                  ipcore_readReady,
   input  logic [3:0]            ipcore_byteEnable,
   input  logic [31:0]           ipcore_address_to_read,
   input  logic [7:0]            ipcore_burst_len,
   input  logic [BUF_ADDR_W-1:0] ipcore_buf_base,
   output logic                  ipcore_switch_ready,
   output logic                  ipcore_done,
   output logic                  ipcore_error,
   output logic [BUF_ADDR_W-1:0] bufferAddress,
   output logic [31:0]           dataIn,
   output logic                  writeEnable,
   input  logic [31:0]           dataOut,
   input  logic [31:0]           address_dataIN,
   input  logic                  end_transactionIN,
   input  logic                  data_validIN,
   input  logic                  busyIN,
   input  logic                  errorIN,
   output logic [31:0]           address_dataOUT,
   output logic [3:0]            byte_enableOUT,
   output logic [7:0]            busrt_sizeOUT,
   output logic                  read_n_writeOUT,
   output logic                  begin_transactionOUT,
   output logic                  end_transactionOUT,
   output logic                  data_validOUT,
   output logic                  busyOUT,
   output logic                  request,
   input  logic                  granted,
   output logic [3:0]            s_dma_cur_state
);
   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      FETCH = 4'd1,
      WREQ  = 4'd2,
      WHS   = 4'd3,
      SEND  = 4'd4,
      WEND  = 4'd5,
      RREQ  = 4'd6,
      RHS   = 4'd7,
      RDATA = 4'd8,
      DONE  = 4'd9
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           addr_q;
   logic [3:0]            be_q;
   logic [7:0]            len_q, len_clamp, len_nxt;
   logic [BUF_ADDR_W-1:0] base_q;
   logic                  err_q;
   logic                  pend_q;
   logic [8:0]            issue_cnt, push_cnt, word_cnt, len9;
   logic                  start, bus_err, owns_bus, issue, pop, flush, rx_wr;
   logic [31:0]           head_dat;
   logic                  head_vld;

   assign len_clamp = (ipcore_burst_len > 8'(MAX_BURST - 1)) ? 8'(MAX_BURST - 1) : ipcore_burst_len;

`ifdef JTAG_DMA_BURST_EN
   localparam int FIFO_DEPTH = MAX_BURST;
   assign len_nxt = len_clamp;
`else
   localparam int FIFO_DEPTH = 1;
   // Single-word build: the latched length is always zero.
   assign len_nxt = len_clamp & 8'h00;
`endif

   assign len9     = {1'b0, len_q};
   assign start    = (state_q == IDLE) && (ipcore_dataReady || ipcore_readReady);
   assign bus_err  = errorIN && (state_q != IDLE) && (state_q != DONE);
   assign owns_bus = (state_q == WHS) || (state_q == SEND) || (state_q == RHS) || (state_q == RDATA);
   assign issue    = (state_q == FETCH) && (issue_cnt <= len9);
   assign pop      = (state_q == SEND) && !busyIN && head_vld && !bus_err;
   assign flush    = (state_q == IDLE) || (state_q == DONE) || bus_err;
   // Words past the latched length are accepted from the bus but never written.
   assign rx_wr    = (state_q == RDATA) && data_validIN && (word_cnt <= len9);

   jtag_dma_fifo #(
      .W     (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .push_vld (pend_q),
      .push_dat (dataOut),
      .pop_rdy  (pop),
      .head_dat (head_dat),
      .head_vld (head_vld)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         be_q      <= '0;
         len_q     <= '0;
         base_q    <= '0;
         err_q     <= 1'b0;
         pend_q    <= 1'b0;
         issue_cnt <= '0;
         push_cnt  <= '0;
         word_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            addr_q <= ipcore_address_to_read;
            be_q   <= ipcore_byteEnable;
            len_q  <= len_nxt;
            base_q <= ipcore_buf_base;
         end
         if (bus_err)    err_q <= 1'b1;
         else if (start) err_q <= 1'b0;
         // Buffer read data arrives one cycle after the address, so the push trails the issue.
         pend_q <= issue;
         if ((state_q == IDLE) || (state_q == DONE)) begin
            issue_cnt <= '0;
            push_cnt  <= '0;
            word_cnt  <= '0;
         end else begin
            if (issue)        issue_cnt <= issue_cnt + 9'd1;
            if (pend_q)       push_cnt  <= push_cnt + 9'd1;
            if (pop || rx_wr) word_cnt  <= word_cnt + 9'd1;
         end
      end
   end

   always_comb begin
      state_d              = state_q;
      ipcore_switch_ready  = 1'b0;
      ipcore_done          = 1'b0;
      request              = 1'b0;
      begin_transactionOUT = 1'b0;
      end_transactionOUT   = 1'b0;
      data_validOUT        = 1'b0;
      read_n_writeOUT      = 1'b0;
      address_dataOUT      = '0;
      byte_enableOUT       = '0;
      busrt_sizeOUT        = '0;
      bufferAddress        = '0;
      writeEnable          = 1'b0;
      dataIn               = '0;

      unique case (state_q)
         IDLE: begin
            ipcore_switch_ready = 1'b1;
            if (ipcore_dataReady)      state_d = FETCH;
            else if (ipcore_readReady) state_d = RREQ;
         end
         FETCH: begin
            if (issue) bufferAddress = base_q + BUF_ADDR_W'(issue_cnt);
            if (pend_q && (push_cnt == len9)) state_d = WREQ;
         end
         WREQ: begin
            request = 1'b1;
            if (granted) state_d = WHS;
         end
         WHS: begin
            begin_transactionOUT = 1'b1;
            address_dataOUT      = addr_q;
            byte_enableOUT       = be_q;
            busrt_sizeOUT        = len_q;
            state_d              = SEND;
         end
         SEND: begin
            data_validOUT   = 1'b1;
            address_dataOUT = head_dat;
            if (pop && (word_cnt == len9)) state_d = WEND;
         end
         WEND: begin
            end_transactionOUT = 1'b1;
            state_d            = DONE;
         end
         RREQ: begin
            request = 1'b1;
            if (granted) state_d = RHS;
         end
         RHS: begin
            begin_transactionOUT = 1'b1;
            read_n_writeOUT      = 1'b1;
            address_dataOUT      = addr_q;
            byte_enableOUT       = be_q;
            busrt_sizeOUT        = len_q;
            state_d              = RDATA;
         end
         RDATA: begin
            if (rx_wr) begin
               writeEnable   = 1'b1;
               bufferAddress = base_q + BUF_ADDR_W'(word_cnt);
               dataIn        = address_dataIN;
            end
            if (end_transactionIN) state_d = DONE;
         end
         DONE: begin
            ipcore_switch_ready = 1'b1;
            ipcore_done         = 1'b1;
            state_d             = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A bus error aborts from any active state; release the bus if we hold it.
      if (bus_err) begin
         state_d = IDLE;
         if (owns_bus) end_transactionOUT = 1'b1;
      end
   end

   assign busyOUT         = 1'b0;
   assign ipcore_error    = err_q;
   assign s_dma_cur_state = state_q;
endmodule

// File: tb/tb_jtag_burst_dma.sv
// Self-checking bench for jtag_burst_dma: scoreboard of expected bus/buffer words, one task per scenario.
module tb_jtag_burst_dma;
   localparam int AW   = 9;
   localparam int MAXB = 16;
`ifdef JTAG_DMA_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          ipcore_dataReady, ipcore_readReady;
   logic [3:0]    ipcore_byteEnable;
   logic [31:0]   ipcore_address_to_read;
   logic [7:0]    ipcore_burst_len;
   logic [AW-1:0] ipcore_buf_base;
   logic          ipcore_switch_ready, ipcore_done, ipcore_error;
   logic [AW-1:0] bufferAddress;
   logic [31:0]   dataIn, dataOut;
   logic          writeEnable;
   logic [31:0]   address_dataIN;
   logic          end_transactionIN, data_validIN, busyIN, errorIN;
   logic [31:0]   address_dataOUT;
   logic [3:0]    byte_enableOUT;
   logic [7:0]    busrt_sizeOUT;
   logic          read_n_writeOUT, begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT;
   logic          request, granted;
   logic [3:0]    s_dma_cur_state;

   logic [31:0]   buf_mem [512];
   logic [31:0]   exp_q[$];
   logic [AW-1:0] exp_a_q[$];
   int            errors = 0;
   int            checks = 0;

   always #5 clock = ~clock;

   jtag_burst_dma #(.BUF_ADDR_W(AW), .MAX_BURST(MAXB)) dut (
      .clock(clock), .reset(reset),
      .ipcore_dataReady(ipcore_dataReady), .ipcore_readReady(ipcore_readReady),
      .ipcore_byteEnable(ipcore_byteEnable), .ipcore_address_to_read(ipcore_address_to_read),
      .ipcore_burst_len(ipcore_burst_len), .ipcore_buf_base(ipcore_buf_base),
      .ipcore_switch_ready(ipcore_switch_ready), .ipcore_done(ipcore_done), .ipcore_error(ipcore_error),
      .bufferAddress(bufferAddress), .dataIn(dataIn), .writeEnable(writeEnable), .dataOut(dataOut),
      .address_dataIN(address_dataIN), .end_transactionIN(end_transactionIN),
      .data_validIN(data_validIN), .busyIN(busyIN), .errorIN(errorIN),
      .address_dataOUT(address_dataOUT), .byte_enableOUT(byte_enableOUT), .busrt_sizeOUT(busrt_sizeOUT),
      .read_n_writeOUT(read_n_writeOUT), .begin_transactionOUT(begin_transactionOUT),
      .end_transactionOUT(end_transactionOUT), .data_validOUT(data_validOUT), .busyOUT(busyOUT),
      .request(request), .granted(granted), .s_dma_cur_state(s_dma_cur_state)
   );

   // Dual-port buffer model: one-cycle read latency, pattern restored while in reset.
   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 512; i++) buf_mem[i] <= 32'hC0DE0000 + i * 32'h00010101;
         dataOut <= '0;
      end else begin
         dataOut <= buf_mem[bufferAddress];
         if (writeEnable) buf_mem[bufferAddress] <= dataIn;
      end
   end

   function automatic int eff_n(input logic [7:0] len);
      if (!BURST) return 1;
      return (int'(len) > MAXB - 1) ? MAXB : int'(len) + 1;
   endfunction

   task automatic idle_inputs();
      ipcore_dataReady = 0; ipcore_readReady = 0; ipcore_byteEnable = 0;
      ipcore_address_to_read = 0; ipcore_burst_len = 0; ipcore_buf_base = 0;
      address_dataIN = 0; end_transactionIN = 0; data_validIN = 0;
      busyIN = 0; errorIN = 0; granted = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 0;
      repeat (3) @(negedge clock);
      #1;
      checks++; if (ipcore_switch_ready !== 1'b1) begin errors++; $display("FAIL reset switch_ready: got %b want 1", ipcore_switch_ready); end
      checks++; if (ipcore_done !== 1'b0 || ipcore_error !== 1'b0) begin errors++; $display("FAIL reset done/error: got %b/%b want 0/0", ipcore_done, ipcore_error); end
      checks++; if ({request, begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT, read_n_writeOUT, writeEnable} !== 7'b0) begin
         errors++; $display("FAIL reset strobes: got %b want 0000000", {request, begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT, read_n_writeOUT, writeEnable}); end
      checks++; if (address_dataOUT !== 32'h0 || bufferAddress !== '0 || busrt_sizeOUT !== 8'h0 || byte_enableOUT !== 4'h0) begin
         errors++; $display("FAIL reset buses: got addr=%h buf=%h size=%h be=%h want all 0", address_dataOUT, bufferAddress, busrt_sizeOUT, byte_enableOUT); end
      reset = 1;
      @(negedge clock);
   endtask

   task automatic test_write_burst(input logic [AW-1:0] base, input logic [31:0] addr, input logic [3:0] be,
                                   input logic [7:0] len, input int busy_word, input int busy_cyc,
                                   input int grant_wait, input bit both, input string tag);
      int n, exp_busy, busy_left, accepted, send_cyc, end_cnt, req_cyc, last_acc, end_cyc;
      bit done_seen, begin_seen;
      logic [AW-1:0] a;
      n = eff_n(len);
      exp_busy = (busy_word < n) ? busy_cyc : 0;
      busy_left = exp_busy;
      accepted = 0; send_cyc = 0; end_cnt = 0; req_cyc = 0; last_acc = -10; end_cyc = -10;
      done_seen = 0; begin_seen = 0;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         a = base + AW'(k);
         exp_q.push_back(buf_mem[a]);
      end
      @(negedge clock);
      ipcore_dataReady = 1; ipcore_readReady = both; ipcore_address_to_read = addr;
      ipcore_byteEnable = be; ipcore_burst_len = len; ipcore_buf_base = base;
      for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
         if (cyc > 0) begin
            @(posedge clock); @(negedge clock);
            ipcore_dataReady = 0; ipcore_readReady = 0;
         end
         #1;
         if (request) begin granted = (req_cyc >= grant_wait); req_cyc++; end
         else granted = 0;
         busyIN = data_validOUT && (accepted == busy_word) && (busy_left > 0);
         if (busyIN) busy_left--;
         #1;
         if (writeEnable || read_n_writeOUT) begin
            checks++; errors++; $display("FAIL %s read path active: we=%b rnw=%b want 0/0", tag, writeEnable, read_n_writeOUT);
         end
         if (begin_transactionOUT) begin
            begin_seen = 1;
            checks++; if (busrt_sizeOUT !== 8'(n - 1)) begin errors++; $display("FAIL %s burst size: got %0d want %0d", tag, busrt_sizeOUT, n - 1); end
            checks++; if (address_dataOUT !== addr || byte_enableOUT !== be) begin errors++; $display("FAIL %s header: got %h/%h want %h/%h", tag, address_dataOUT, byte_enableOUT, addr, be); end
            checks++; if (req_cyc !== grant_wait + 1 || request !== 1'b0) begin errors++; $display("FAIL %s request span: got %0d cycles req=%b want %0d req=0", tag, req_cyc, request, grant_wait + 1); end
         end
         if (data_validOUT) begin
            send_cyc++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL %s extra word: got %h want none", tag, address_dataOUT); end
            else begin
               if (address_dataOUT !== exp_q[0]) begin errors++; $display("FAIL %s word %0d: got %h want %h", tag, accepted, address_dataOUT, exp_q[0]); end
               if (!busyIN) begin void'(exp_q.pop_front()); accepted++; last_acc = cyc; end
            end
         end
         if (end_transactionOUT) begin
            end_cnt++; end_cyc = cyc;
            checks++; if (cyc !== last_acc + 1 || accepted !== n) begin errors++; $display("FAIL %s end timing: got cyc=%0d words=%0d want cyc=%0d words=%0d", tag, cyc, accepted, last_acc + 1, n); end
         end
         if (ipcore_done) begin
            done_seen = 1;
            checks++; if (cyc !== end_cyc + 1) begin errors++; $display("FAIL %s done timing: got cyc=%0d want %0d", tag, cyc, end_cyc + 1); end
         end
      end
      busyIN = 0; granted = 0;
      checks++; if (!done_seen || !begin_seen) begin errors++; $display("FAIL %s timeout: got done=%b begin=%b want 1/1", tag, done_seen, begin_seen); end
      checks++; if (send_cyc !== n + exp_busy) begin errors++; $display("FAIL %s send cycles: got %0d want %0d", tag, send_cyc, n + exp_busy); end
      checks++; if (end_cnt !== 1 || exp_q.size() !== 0) begin errors++; $display("FAIL %s end count/leftover: got %0d/%0d want 1/0", tag, end_cnt, exp_q.size()); end
   endtask

   task automatic test_read_burst(input logic [AW-1:0] base, input logic [31:0] addr, input logic [3:0] be,
                                  input logic [7:0] len, input string tag);
      int n, sent, phase, end_cyc;
      bit in_data, done_seen;
      n = eff_n(len);
      sent = 0; phase = 0; end_cyc = -10; in_data = 0; done_seen = 0;
      exp_q.delete(); exp_a_q.delete();
      @(negedge clock);
      ipcore_readReady = 1; ipcore_address_to_read = addr; ipcore_byteEnable = be;
      ipcore_burst_len = len; ipcore_buf_base = base;
      for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
         if (cyc > 0) begin
            @(posedge clock); @(negedge clock);
            ipcore_readReady = 0;
         end
         data_validIN = 0; end_transactionIN = 0;
         if (in_data) begin
            if (phase % 2 == 0 && sent < 3) begin
               data_validIN = 1;
               address_dataIN = 32'hD00D0000 + sent * 32'h1111 + 32'(base);
               end_transactionIN = (sent == 2);
               if (sent < n) begin
                  exp_q.push_back(address_dataIN);
                  exp_a_q.push_back(base + AW'(sent));
               end
               if (end_transactionIN) end_cyc = cyc;
               sent++;
            end
            phase++;
         end
         #1;
         granted = request;
         #1;
         if (begin_transactionOUT) begin
            in_data = 1;
            checks++; if (read_n_writeOUT !== 1'b1 || busrt_sizeOUT !== 8'(n - 1)) begin errors++; $display("FAIL %s rd header: got rnw=%b size=%0d want 1/%0d", tag, read_n_writeOUT, busrt_sizeOUT, n - 1); end
            checks++; if (address_dataOUT !== addr || byte_enableOUT !== be) begin errors++; $display("FAIL %s rd addr/be: got %h/%h want %h/%h", tag, address_dataOUT, byte_enableOUT, addr, be); end
         end
         if (writeEnable) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL %s extra buffer write: got %h@%h want none", tag, dataIn, bufferAddress); end
            else begin
               if (bufferAddress !== exp_a_q[0] || dataIn !== exp_q[0]) begin
                  errors++; $display("FAIL %s buffer write: got %h@%h want %h@%h", tag, dataIn, bufferAddress, exp_q[0], exp_a_q[0]); end
               void'(exp_q.pop_front()); void'(exp_a_q.pop_front());
            end
         end
         if (ipcore_done) begin
            done_seen = 1;
            checks++; if (cyc !== end_cyc + 1) begin errors++; $display("FAIL %s rd done timing: got cyc=%0d want %0d", tag, cyc, end_cyc + 1); end
         end
      end
      idle_inputs();
      checks++; if (!done_seen || exp_q.size() !== 0) begin errors++; $display("FAIL %s rd completion: got done=%b left=%0d want 1/0", tag, done_seen, exp_q.size()); end
   endtask

   task automatic test_error();
      bit seen;
      seen = 0;
      @(negedge clock);
      ipcore_dataReady = 1; ipcore_address_to_read = 32'h40000300; ipcore_byteEnable = 4'hF;
      ipcore_burst_len = 8'd3; ipcore_buf_base = 9'h020;
      for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
         if (cyc > 0) begin @(posedge clock); @(negedge clock); ipcore_dataReady = 0; end
         #1;
         granted = request;
         seen = data_validOUT;
      end
      checks++; if (!seen) begin errors++; $display("FAIL err reach SEND: got %b want 1", seen); end
      busyIN = 1;
      @(posedge clock); @(negedge clock);
      busyIN = 0; errorIN = 1; granted = 0;
      #1;
      checks++; if (end_transactionOUT !== 1'b1 || data_validOUT !== 1'b1) begin errors++; $display("FAIL err end pulse: got end=%b valid=%b want 1/1", end_transactionOUT, data_validOUT); end
      @(posedge clock); @(negedge clock);
      errorIN = 0;
      #1;
      checks++; if (ipcore_switch_ready !== 1'b1 || ipcore_done !== 1'b0 || end_transactionOUT !== 1'b0) begin
         errors++; $display("FAIL err idle: got ready=%b done=%b end=%b want 1/0/0", ipcore_switch_ready, ipcore_done, end_transactionOUT); end
      checks++; if (ipcore_error !== 1'b1) begin errors++; $display("FAIL err sticky: got %b want 1", ipcore_error); end
      ipcore_readReady = 1; ipcore_address_to_read = 32'h80000000; ipcore_burst_len = 8'd0;
      @(posedge clock); @(negedge clock);
      ipcore_readReady = 0;
      #1;
      checks++; if (ipcore_error !== 1'b0 || request !== 1'b1) begin errors++; $display("FAIL err clear: got err=%b req=%b want 0/1", ipcore_error, request); end
      granted = 1;
      @(posedge clock); @(negedge clock);
      granted = 0;
      @(posedge clock); @(negedge clock);
      end_transactionIN = 1;
      @(posedge clock); @(negedge clock);
      end_transactionIN = 0;
      #1;
      checks++; if (ipcore_done !== 1'b1) begin errors++; $display("FAIL err recovery read done: got %b want 1", ipcore_done); end
   endtask

   task automatic test_reset_abort();
      bit seen;
      seen = 0;
      @(negedge clock);
      ipcore_dataReady = 1; ipcore_address_to_read = 32'h40000400; ipcore_byteEnable = 4'hF;
      ipcore_burst_len = 8'd2; ipcore_buf_base = 9'h040;
      for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
         if (cyc > 0) begin @(posedge clock); @(negedge clock); ipcore_dataReady = 0; end
         #1;
         granted = request;
         seen = data_validOUT;
      end
      checks++; if (!seen) begin errors++; $display("FAIL abort reach SEND: got %b want 1", seen); end
      reset = 0;
      #1;
      checks++; if (end_transactionOUT !== 1'b0 || data_validOUT !== 1'b0 || ipcore_switch_ready !== 1'b1) begin
         errors++; $display("FAIL abort outputs: got end=%b valid=%b ready=%b want 0/0/1", end_transactionOUT, data_validOUT, ipcore_switch_ready); end
      idle_inputs();
      @(posedge clock); @(negedge clock);
      reset = 1;
   endtask

   initial begin
      test_reset();
      test_write_burst(9'h010, 32'h40000100, 4'hF, 8'd3, 99, 0, 0, 1'b0, "wr4");
      test_write_burst(9'h010, 32'h40000100, 4'hF, 8'd3, 2, 3, 0, 1'b0, "wr4_busy");
      test_read_burst(9'h1FE, 32'h80000040, 4'h3, 8'd2, "rd3_wrap");
      test_error();
      test_write_burst(9'h030, 32'h40000200, 4'h5, 8'd1, 99, 0, 2, 1'b1, "both_start");
      test_write_burst(9'h1F8, 32'h40001000, 4'hF, 8'd255, 0, 1, 1, 1'b0, "clamp");
      test_reset_abort();
      test_write_burst(9'h050, 32'h40002000, 4'hC, 8'd1, 99, 0, 0, 1'b0, "post_abort");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
